// File: rtl/bus_dev_endpoint_if.sv
// rtl/bus_dev_endpoint_if.sv - host/bus handshake bundle for one bus_dev_endpoint port
// master = host plus bus side, slave = the endpoint itself.
interface bus_dev_endpoint_if #(
    parameter int pckg_sz = 16
) ();
    logic               tx_valid;
    logic               tx_ready;
    logic [pckg_sz-1:0] tx_data;
    logic               pndng;
    logic               pop;
    logic [pckg_sz-1:0] D_pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               rx_valid;
    logic               rx_ready;
    logic [pckg_sz-1:0] rx_data;

    modport master (
        output tx_valid, tx_data, pop, push, D_push, rx_ready,
        input  tx_ready, pndng, D_pop, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data, pop, push, D_push, rx_ready,
        output tx_ready, pndng, D_pop, rx_valid, rx_data
    );
endinterface

// File: rtl/bus_dev_endpoint.sv
// rtl/bus_dev_endpoint.sv - device endpoint: host transmit FIFO toward the bus, filtered receive FIFO from it
// Both FIFOs are first-word fall-through; outputs depend on registered state only.
module bus_dev_endpoint #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF,
    parameter logic [7:0] id        = 8'd0,
    parameter int         depth     = 8,
    localparam int        cw        = $clog2(depth) + 1
) (
    input  logic          clk,
    input  logic          reset,
    bus_dev_endpoint_if.slave bus,
    output logic [cw-1:0] tx_count,
    output logic [cw-1:0] rx_count,
    output logic [7:0]    drop_cnt,
    output logic [7:0]    misroute_cnt,
    output logic          underflow
);
    localparam int            aw       = $clog2(depth);
    localparam logic [cw-1:0] full_lvl = cw'(depth);

    if (bits < 1 || drvrs < 1 || int'(id) >= drvrs || pckg_sz < 9 ||
        depth < 2 || (depth & (depth - 1)) != 0) begin : g_param_check
        $error("bus_dev_endpoint: illegal parameter combination");
    end

    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [aw-1:0]      tx_wp, tx_rp, rx_wp, rx_rp;

    logic       tx_wr, tx_rd;
    logic       rx_cand, rx_wr, rx_rd, rx_drop, misroute;
    logic       bad_read;
    logic [7:0] dest;

    assign bus.tx_ready = (tx_count != full_lvl);
    assign bus.pndng    = (tx_count != '0);
    assign bus.D_pop    = bus.pndng ? tx_mem[tx_rp] : '0;
    assign bus.rx_valid = (rx_count != '0);
    assign bus.rx_data  = bus.rx_valid ? rx_mem[rx_rp] : '0;

    always_comb begin
        dest     = bus.D_push[pckg_sz-1 -: 8];
        tx_wr    = bus.tx_valid & bus.tx_ready;
        tx_rd    = bus.pop & bus.pndng;
        rx_rd    = bus.rx_ready & bus.rx_valid;
        rx_cand  = bus.push & ((dest == id) | (dest == broadcast));
        misroute = bus.push & ~rx_cand;
        // A full receive FIFO still takes a packet when the host drains one in the same cycle.
        rx_wr    = rx_cand & ((rx_count != full_lvl) | rx_rd);
        rx_drop  = rx_cand & ~rx_wr;
        bad_read = (bus.pop & ~bus.pndng) | (bus.rx_ready & ~bus.rx_valid);
    end

    always_ff @(posedge clk) begin
        if (!reset && tx_wr) begin
            tx_mem[tx_wp] <= bus.tx_data;
        end
        if (!reset && rx_wr) begin
            rx_mem[rx_wp] <= bus.D_push;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp        <= '0;
            tx_rp        <= '0;
            rx_wp        <= '0;
            rx_rp        <= '0;
            tx_count     <= '0;
            rx_count     <= '0;
            drop_cnt     <= '0;
            misroute_cnt <= '0;
            underflow    <= 1'b0;
        end else begin
            if (tx_wr) tx_wp <= tx_wp + 1'b1;
            if (tx_rd) tx_rp <= tx_rp + 1'b1;
            if (rx_wr) rx_wp <= rx_wp + 1'b1;
            if (rx_rd) rx_rp <= rx_rp + 1'b1;

            case ({tx_wr, tx_rd})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase

            case ({rx_wr, rx_rd})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase

            if (rx_drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (misroute && misroute_cnt != 8'hFF) begin
                misroute_cnt <= misroute_cnt + 8'd1;
            end
            if (bad_read) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// tb/tb_bus_dev_endpoint.sv - directed plus random bench for bus_dev_endpoint against a queue model
module tb_bus_dev_endpoint;
    localparam int         PW    = 16;
    localparam int         DEPTH = 4;
    localparam int         CW    = 3;
    localparam logic [7:0] ID    = 8'h02;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_dev_endpoint_if #(.pckg_sz(PW)) bif ();

    logic [CW-1:0] tx_count, rx_count;
    logic [7:0]    drop_cnt, misroute_cnt;
    logic          underflow;

    bus_dev_endpoint #(
        .bits(1), .drvrs(4), .pckg_sz(PW), .broadcast(8'hFF), .id(ID), .depth(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif),
        .tx_count(tx_count),
        .rx_count(rx_count),
        .drop_cnt(drop_cnt),
        .misroute_cnt(misroute_cnt),
        .underflow(underflow)
    );

    int tests = 0;
    int fails = 0;

    logic [PW-1:0] txq[$];
    logic [PW-1:0] rxq[$];
    int            m_drop, m_mis;
    bit            m_uf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit         tw, tr, rr, cand, rw;
        logic [7:0] d;
        if (reset) begin
            txq.delete();
            rxq.delete();
            m_drop = 0;
            m_mis  = 0;
            m_uf   = 1'b0;
        end else begin
            tw   = bif.tx_valid && txq.size() < DEPTH;
            tr   = bif.pop && txq.size() > 0;
            rr   = bif.rx_ready && rxq.size() > 0;
            d    = bif.D_push[PW-1:PW-8];
            cand = bif.push && (d == ID || d == 8'hFF);
            rw   = cand && (rxq.size() < DEPTH || rr);
            if (bif.pop && txq.size() == 0) m_uf = 1'b1;
            if (bif.rx_ready && rxq.size() == 0) m_uf = 1'b1;
            if (tr) void'(txq.pop_front());
            if (tw) txq.push_back(bif.tx_data);
            if (rr) void'(rxq.pop_front());
            if (rw) rxq.push_back(bif.D_push);
            if (cand && !rw && m_drop < 255) m_drop++;
            if (bif.push && !cand && m_mis < 255) m_mis++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/tx_ready"}, 32'(bif.tx_ready), 32'(txq.size() < DEPTH));
        check({tag, "/pndng"}, 32'(bif.pndng), 32'(txq.size() > 0));
        check({tag, "/D_pop"}, 32'(bif.D_pop), txq.size() > 0 ? 32'(txq[0]) : 32'd0);
        check({tag, "/tx_count"}, 32'(tx_count), 32'(txq.size()));
        check({tag, "/rx_valid"}, 32'(bif.rx_valid), 32'(rxq.size() > 0));
        check({tag, "/rx_data"}, 32'(bif.rx_data), rxq.size() > 0 ? 32'(rxq[0]) : 32'd0);
        check({tag, "/rx_count"}, 32'(rx_count), 32'(rxq.size()));
        check({tag, "/drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        check({tag, "/misroute_cnt"}, 32'(misroute_cnt), 32'(m_mis));
        check({tag, "/underflow"}, 32'(underflow), 32'(m_uf));
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        bif.tx_valid = 1'b0;
        bif.tx_data  = '0;
        bif.pop      = 1'b0;
        bif.push     = 1'b0;
        bif.D_push   = '0;
        bif.rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc("reset");
        reset = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] words[$];
        logic [PW-1:0] exp_words [4];
        int            n;
        logic [7:0]    d;

        idle();
        reset = 1'b1;
        cyc("reset0");
        cyc("reset1");
        check("reset_tx_ready", 32'(bif.tx_ready), 32'd1);
        check("reset_tx_count", 32'(tx_count), 32'd0);
        reset = 1'b0;

        exp_words = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};
        for (int i = 0; i < 4; i++) begin
            bif.tx_valid = 1'b1;
            bif.tx_data  = exp_words[i];
            cyc("tx_fill");
        end
        check("tx_full_ready", 32'(bif.tx_ready), 32'd0);
        check("tx_full_count", 32'(tx_count), 32'd4);
        bif.tx_data = 16'h0555;
        cyc("tx_overoffer");
        check("tx_overoffer_count", 32'(tx_count), 32'd4);
        bif.tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tx_drain_order", 32'(bif.D_pop), 32'(exp_words[i]));
            bif.pop = 1'b1;
            cyc("tx_drain");
        end
        bif.pop = 1'b0;
        check("tx_empty_pndng", 32'(bif.pndng), 32'd0);

        bif.push = 1'b1;
        bif.D_push = 16'h02AB; cyc("rx_filter");
        bif.D_push = 16'hFFCD; cyc("rx_filter");
        bif.D_push = 16'h03EF; cyc("rx_filter");
        bif.push = 1'b0;
        check("rx_filter_mis", 32'(misroute_cnt), 32'd1);
        check("rx_filter_count", 32'(rx_count), 32'd2);
        check("rx_head0", 32'(bif.rx_data), 32'h02AB);
        bif.rx_ready = 1'b1;
        cyc("rx_read");
        check("rx_head1", 32'(bif.rx_data), 32'hFFCD);
        cyc("rx_read");
        bif.rx_ready = 1'b0;

        do_reset();
        bif.push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bif.D_push = 16'h0210 + 16'(i);
            cyc("rx_fill");
        end
        bif.D_push = 16'h0201;
        cyc("rx_drop");
        check("rx_drop_cnt", 32'(drop_cnt), 32'd1);
        check("rx_drop_head", 32'(bif.rx_data), 32'h0210);
        bif.rx_ready = 1'b1;
        cyc("rx_full_pop");
        check("rx_full_pop_count", 32'(rx_count), 32'd4);
        check("rx_full_pop_drop", 32'(drop_cnt), 32'd1);
        bif.rx_ready = 1'b0;
        for (int i = 0; i < 300; i++) cyc("rx_sat");
        check("rx_drop_sat", 32'(drop_cnt), 32'd255);
        bif.push = 1'b0;

        do_reset();
        bif.tx_valid = 1'b1;
        bif.tx_data  = 16'h0A01;
        cyc("tx_one");
        bif.tx_data = 16'h0A02;
        bif.pop     = 1'b1;
        cyc("tx_wr_pop");
        check("tx_wr_pop_count", 32'(tx_count), 32'd1);
        check("tx_wr_pop_head", 32'(bif.D_pop), 32'h0A02);
        idle();
        bif.pop = 1'b1;
        cyc("tx_flush");
        bif.pop = 1'b0;
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 4);
            words.delete();
            bif.tx_valid = 1'b1;
            for (int k = 0; k < n; k++) begin
                bif.tx_data = 16'($urandom);
                words.push_back(bif.tx_data);
                cyc("wrap_fill");
            end
            bif.tx_valid = 1'b0;
            bif.pop = 1'b1;
            for (int k = 0; k < n; k++) begin
                check("wrap_order", 32'(bif.D_pop), 32'(words[k]));
                cyc("wrap_drain");
            end
            bif.pop = 1'b0;
        end

        do_reset();
        bif.pop = 1'b1;
        cyc("uflow_pop");
        check("uflow_flag", 32'(underflow), 32'd1);
        check("uflow_count", 32'(tx_count), 32'd0);
        idle();
        bif.tx_valid = 1'b1;
        bif.push     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.tx_data = 16'h0B00 + 16'(i);
            bif.D_push  = 16'h0200 + 16'(i);
            cyc("pre_reset_fill");
        end
        bif.pop = 1'b1;
        reset   = 1'b1;
        cyc("mid_reset");
        reset = 1'b0;
        check("mid_reset_tx_ready", 32'(bif.tx_ready), 32'd1);
        check("mid_reset_rx_count", 32'(rx_count), 32'd0);
        check("mid_reset_uflow", 32'(underflow), 32'd0);
        idle();

        for (int i = 0; i < 500; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            bif.tx_valid = $urandom_range(0, 1) == 1;
            bif.tx_data  = 16'($urandom);
            bif.pop      = $urandom_range(0, 2) == 0;
            bif.push     = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       d = 8'hFF;
                1:       d = 8'h01;
                default: d = ID;
            endcase
            bif.D_push   = {d, 8'($urandom)};
            bif.rx_ready = $urandom_range(0, 2) == 0;
            cyc("random");
        end
        reset = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
